// File: rtl/rob_commit_pkg.sv
// Shared configuration and types for the ROB retire path.
// The head-pointer block imports the same constants.
package rob_commit_pkg;

  localparam int unsigned RENTRIES = 16;
  localparam int unsigned RSLOTS   = 2;
  localparam int unsigned RBITS    = $clog2(RENTRIES);

  typedef logic [RBITS-1:0] rid_t;

  typedef enum logic [1:0] {
    RUN,
    ST_WAIT,
    FLUSH
  } state_e;

  // Why the in-order scan stopped at the first non-candidate slot.
  typedef enum logic [1:0] {
    STOP_NONE,
    STOP_BLOCK,
    STOP_STORE,
    STOP_EXC
  } stop_e;

endpackage

// File: rtl/rob_commit_if.sv
// Interface between the retire controller and the ROB / store buffer / head-pointer side.
interface rob_commit_if #(
  parameter int unsigned RENTRIES = rob_commit_pkg::RENTRIES
);
  localparam int unsigned RBITS = $clog2(RENTRIES);

  logic [RBITS-1:0]    rob_head;
  logic [RENTRIES-1:0] rob_v;
  logic [RENTRIES-1:0] rob_done;
  logic [RENTRIES-1:0] rob_exc;
  logic [RENTRIES-1:0] rob_store;
  logic                st_ack;

  logic [2:0]          ramt;
  logic                st_req;
  logic [RBITS-1:0]    st_id;
  logic                exc_take;
  logic [RBITS-1:0]    exc_id;
  logic                flush;
  logic [31:0]         commit_cnt;

  modport master (
    output rob_head, rob_v, rob_done, rob_exc, rob_store, st_ack,
    input  ramt, st_req, st_id, exc_take, exc_id, flush, commit_cnt
  );

  modport slave (
    input  rob_head, rob_v, rob_done, rob_exc, rob_store, st_ack,
    output ramt, st_req, st_id, exc_take, exc_id, flush, commit_cnt
  );

endinterface

// File: rtl/rob_commit_scan.sv
// Combinational in-order scan of the RSLOTS entries at the ROB head:
// leading retire-ready count, plus the kind and index of the first stopping slot.
module rob_commit_scan
  import rob_commit_pkg::*;
#(
  parameter int unsigned RENTRIES = rob_commit_pkg::RENTRIES,
  parameter int unsigned RSLOTS   = rob_commit_pkg::RSLOTS
) (
  input  logic [$clog2(RENTRIES)-1:0] i_head,
  input  logic [RENTRIES-1:0]         i_v,
  input  logic [RENTRIES-1:0]         i_done,
  input  logic [RENTRIES-1:0]         i_exc,
  input  logic [RENTRIES-1:0]         i_store,
  output logic [2:0]                  o_cnt,
  output stop_e                       o_stop,
  output logic [$clog2(RENTRIES)-1:0] o_stop_id
);

  localparam int unsigned IBITS = $clog2(RENTRIES);

  logic [IBITS-1:0] w_idx;
  logic             w_run;

  always_comb begin
    o_cnt     = '0;
    o_stop    = STOP_NONE;
    o_stop_id = '0;
    w_idx     = i_head;
    w_run     = 1'b1;
    for (int unsigned k = 0; k < RSLOTS; k++) begin
      // Slot index wraps by truncation to the ROB index width.
      w_idx = i_head + IBITS'(k);
      if (w_run) begin
        if (i_v[w_idx] && i_done[w_idx] && !i_exc[w_idx] && !i_store[w_idx]) begin
          o_cnt = o_cnt + 3'd1;
        end else begin
          w_run     = 1'b0;
          o_stop_id = w_idx;
          if (!i_v[w_idx] || !i_done[w_idx]) begin
            o_stop = STOP_BLOCK;
          end else if (i_exc[w_idx]) begin
            o_stop = STOP_EXC;
          end else begin
            o_stop = STOP_STORE;
          end
        end
      end
    end
  end

endmodule

// File: rtl/rob_commit.sv
// Retire-stage controller: decides per-cycle retire amount, sequences
// store retirement with the store buffer and exception flushes.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int unsigned RENTRIES     = rob_commit_pkg::RENTRIES,
  parameter int unsigned RSLOTS       = rob_commit_pkg::RSLOTS,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  rob_commit_if.slave   bus
);

  localparam int unsigned IBITS = $clog2(RENTRIES);
  localparam int unsigned FCW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [2:0]       w_cnt;
  stop_e            w_stop;
  logic [IBITS-1:0] w_stop_id;

  state_e           r_state;
  state_e           w_next;
  logic [FCW-1:0]   r_fcnt;
  logic [FCW-1:0]   w_fcnt_nxt;
  logic [IBITS-1:0] r_exc_id;
  logic [IBITS-1:0] w_exc_id_nxt;
  logic [IBITS-1:0] r_st_id;
  logic [IBITS-1:0] w_st_id_nxt;
  logic [31:0]      r_commit;

  logic [2:0]       w_ramt;
  logic             w_st_req;
  logic [IBITS-1:0] w_st_id;
  logic             w_exc_take;

  rob_commit_scan #(
    .RENTRIES (RENTRIES),
    .RSLOTS   (RSLOTS)
  ) u_scan (
    .i_head    (bus.rob_head),
    .i_v       (bus.rob_v),
    .i_done    (bus.rob_done),
    .i_exc     (bus.rob_exc),
    .i_store   (bus.rob_store),
    .o_cnt     (w_cnt),
    .o_stop    (w_stop),
    .o_stop_id (w_stop_id)
  );

  always_comb begin
    w_next       = r_state;
    w_fcnt_nxt   = r_fcnt;
    w_exc_id_nxt = r_exc_id;
    w_st_id_nxt  = r_st_id;
    w_ramt       = '0;
    w_st_req     = 1'b0;
    w_st_id      = r_st_id;
    w_exc_take   = 1'b0;
    unique case (r_state)
      RUN: begin
        w_ramt = w_cnt;
        // Stores and exceptions only act once every older entry has retired.
        if (w_cnt == 3'd0) begin
          case (w_stop)
            STOP_STORE: begin
              w_st_req    = 1'b1;
              w_st_id     = w_stop_id;
              w_st_id_nxt = w_stop_id;
              if (bus.st_ack) begin
                w_ramt = 3'd1;
              end else begin
                w_next = ST_WAIT;
              end
            end
            STOP_EXC: begin
              w_ramt       = 3'd1;
              w_exc_take   = 1'b1;
              w_exc_id_nxt = w_stop_id;
              w_fcnt_nxt   = FCW'(FLUSH_CYCLES - 1);
              w_next       = FLUSH;
            end
            default: ;
          endcase
        end
      end
      ST_WAIT: begin
        w_st_req = 1'b1;
        if (bus.st_ack) begin
          w_ramt = 3'd1;
          w_next = RUN;
        end
      end
      FLUSH: begin
        if (r_fcnt == '0) begin
          w_next = RUN;
        end else begin
          w_fcnt_nxt = r_fcnt - 1'b1;
        end
      end
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_fcnt   <= '0;
      r_exc_id <= '0;
      r_st_id  <= '0;
      r_commit <= '0;
    end else begin
      r_state  <= w_next;
      r_fcnt   <= w_fcnt_nxt;
      r_exc_id <= w_exc_id_nxt;
      r_st_id  <= w_st_id_nxt;
      r_commit <= r_commit + 32'(w_ramt);
    end
  end

  assign bus.ramt       = w_ramt;
  assign bus.st_req     = w_st_req;
  assign bus.st_id      = w_st_id;
  assign bus.exc_take   = w_exc_take;
  assign bus.exc_id     = r_exc_id;
  assign bus.flush      = (r_state == FLUSH);
  assign bus.commit_cnt = r_commit;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: each stimulus cycle queues its expected
// outputs, and a negedge monitor pops and compares them.
module tb_rob_commit;
  import rob_commit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rob_commit_if #(.RENTRIES(16)) bus ();

  rob_commit #(
    .RENTRIES     (16),
    .RSLOTS       (2),
    .FLUSH_CYCLES (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       nm;
    logic [2:0]  ramt;
    logic        st_req;
    logic [3:0]  st_id;
    logic        exc_take;
    logic [3:0]  exc_id;
    logic        flush;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_cnt = '0;
  logic [3:0]  exp_exc_id = '0;

  function automatic void chk(input string nm, input string fld,
                              input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0h exp=%0h", nm, fld, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      chk(m_e.nm, "ramt",       32'(bus.ramt),     32'(m_e.ramt));
      chk(m_e.nm, "st_req",     32'(bus.st_req),   32'(m_e.st_req));
      if (m_e.st_req)
        chk(m_e.nm, "st_id",    32'(bus.st_id),    32'(m_e.st_id));
      chk(m_e.nm, "exc_take",   32'(bus.exc_take), 32'(m_e.exc_take));
      chk(m_e.nm, "exc_id",     32'(bus.exc_id),   32'(m_e.exc_id));
      chk(m_e.nm, "flush",      32'(bus.flush),    32'(m_e.flush));
      chk(m_e.nm, "commit_cnt", bus.commit_cnt,    m_e.cnt);
    end
  end

  task automatic cyc(input string nm, input logic [3:0] head,
                     input logic [15:0] v, input logic [15:0] d,
                     input logic [15:0] e, input logic [15:0] s,
                     input logic ack, input logic r,
                     input logic [2:0] e_ramt, input logic e_req,
                     input logic [3:0] e_id, input logic e_exc,
                     input logic e_flush);
    exp_t x;
    rst           = r;
    bus.rob_head  = head;
    bus.rob_v     = v;
    bus.rob_done  = d;
    bus.rob_exc   = e;
    bus.rob_store = s;
    bus.st_ack    = ack;
    x.nm       = nm;
    x.ramt     = e_ramt;
    x.st_req   = e_req;
    x.st_id    = e_id;
    x.exc_take = e_exc;
    x.exc_id   = exp_exc_id;
    x.flush    = e_flush;
    x.cnt      = exp_cnt;
    q.push_back(x);
    @(posedge clk);
    #1;
    if (r) begin
      exp_cnt    = '0;
      exp_exc_id = '0;
    end else begin
      exp_cnt = exp_cnt + 32'(e_ramt);
      if (e_exc) exp_exc_id = head;
    end
  endtask

  initial begin
    bus.rob_head  = '0;
    bus.rob_v     = '0;
    bus.rob_done  = '0;
    bus.rob_exc   = '0;
    bus.rob_store = '0;
    bus.st_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    //   name          head  v        done     exc      store    ack rst ramt req id  exc fl
    cyc("reset",       4'd0, 16'h0000,16'h0000,16'h0000,16'h0000,0,  0,  3'd0,0, 4'd0,0, 0);
    cyc("wrap",        4'd14,16'hC000,16'hC000,16'h0000,16'h0000,0,  0,  3'd2,0, 4'd0,0, 0);
    cyc("wrap_after",  4'd0, 16'h0000,16'h0000,16'h0000,16'h0000,0,  0,  3'd0,0, 4'd0,0, 0);
    cyc("partial",     4'd3, 16'h0018,16'h0008,16'h0000,16'h0000,0,  0,  3'd1,0, 4'd0,0, 0);
    cyc("blocked",     4'd4, 16'h0010,16'h0000,16'h0000,16'h0000,0,  0,  3'd0,0, 4'd0,0, 0);
    cyc("gap",         4'd2, 16'h0004,16'h000C,16'h0000,16'h0000,0,  0,  3'd1,0, 4'd0,0, 0);
    cyc("cap",         4'd0, 16'hFFFF,16'hFFFF,16'h0000,16'h0000,0,  0,  3'd2,0, 4'd0,0, 0);
    for (int i = 0; i < 3; i++)
      cyc("st_wait",   4'd5, 16'h0020,16'h0020,16'h0000,16'h0020,0,  0,  3'd0,1, 4'd5,0, 0);
    cyc("st_ack",      4'd5, 16'h0020,16'h0020,16'h0000,16'h0020,1,  0,  3'd1,1, 4'd5,0, 0);
    cyc("st_done",     4'd6, 16'h0000,16'h0000,16'h0000,16'h0000,0,  0,  3'd0,0, 4'd0,0, 0);
    cyc("st_same",     4'd6, 16'h0040,16'h0040,16'h0000,16'h0040,1,  0,  3'd1,1, 4'd6,0, 0);
    cyc("st_same_run", 4'd7, 16'h0000,16'h0000,16'h0000,16'h0000,0,  0,  3'd0,0, 4'd0,0, 0);
    cyc("stray_ack",   4'd7, 16'h0000,16'h0000,16'h0000,16'h0000,1,  0,  3'd0,0, 4'd0,0, 0);
    cyc("st_behind",   4'd10,16'h0C00,16'h0C00,16'h0000,16'h0800,0,  0,  3'd1,0, 4'd0,0, 0);
    cyc("st_req2",     4'd11,16'h0800,16'h0800,16'h0000,16'h0800,0,  0,  3'd0,1, 4'd11,0,0);
    cyc("st_ack2",     4'd11,16'h0800,16'h0800,16'h0000,16'h0800,1,  0,  3'd1,1, 4'd11,0,0);
    cyc("exc_pre",     4'd7, 16'h0180,16'h0180,16'h0100,16'h0000,0,  0,  3'd1,0, 4'd0,0, 0);
    cyc("exc_take",    4'd8, 16'h0100,16'h0100,16'h0100,16'h0000,0,  0,  3'd1,0, 4'd0,1, 0);
    for (int i = 0; i < 3; i++)
      cyc("flush",     4'd9, 16'h0000,16'h0000,16'h0000,16'h0000,0,  0,  3'd0,0, 4'd0,0, 1);
    cyc("flush_end",   4'd9, 16'h0000,16'h0000,16'h0000,16'h0000,0,  0,  3'd0,0, 4'd0,0, 0);
    cyc("st_exc",      4'd12,16'h1000,16'h1000,16'h1000,16'h1000,0,  0,  3'd1,0, 4'd0,1, 0);
    cyc("rst_flush1",  4'd13,16'h0000,16'h0000,16'h0000,16'h0000,0,  0,  3'd0,0, 4'd0,0, 1);
    cyc("rst_flush2",  4'd13,16'h0000,16'h0000,16'h0000,16'h0000,0,  1,  3'd0,0, 4'd0,0, 1);
    cyc("rst_after",   4'd0, 16'h0000,16'h0000,16'h0000,16'h0000,0,  0,  3'd0,0, 4'd0,0, 0);
    cyc("st_pre_rst",  4'd5, 16'h0020,16'h0020,16'h0000,16'h0020,0,  0,  3'd0,1, 4'd5,0, 0);
    cyc("st_rst",      4'd5, 16'h0020,16'h0020,16'h0000,16'h0020,0,  1,  3'd0,1, 4'd5,0, 0);
    cyc("st_rst_after",4'd5, 16'h0000,16'h0000,16'h0000,16'h0000,1,  0,  3'd0,0, 4'd0,0, 0);
    cyc("post_rst",    4'd0, 16'h0003,16'h0003,16'h0000,16'h0000,0,  0,  3'd2,0, 4'd0,0, 0);
    for (int i = 0; i < 10; i++)
      cyc("empty",     4'd2, 16'h0000,16'hFFFF,16'h0000,16'h0000,0,  0,  3'd0,0, 4'd0,0, 0);

    @(negedge clk);
    chk("end", "queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Retire-stage controller that feeds the head-pointer block.
- Each cycle it examines the RSLOTS ROB entries starting at the current ROB head and decides how many retire in order.
- It drives ramt, which the head-pointer block adds to its pointers. It also handles store retirement (handshake with the store buffer) and exception flush sequencing.

Parameters:
- RENTRIES, 16, ROB entry count; power of two, index width RBITS = log2(RENTRIES).
- RSLOTS, 2, maximum retirements per cycle; range 1..7.
- FLUSH_CYCLES, 3, cycles flush is held asserted after an exception retires.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rob_head  in  RBITS  current ROB head index, driven by the head-pointer block.
- rob_v  in  RENTRIES  entry valid bits.
- rob_done  in  RENTRIES  entry has completed execution.
- rob_exc  in  RENTRIES  entry completed with an exception.
- rob_store  in  RENTRIES  entry is a store.
- st_ack  in  1  store buffer accepted the committing store.
- ramt  out  3  number of entries retired this cycle; combinational.
- st_req  out  1  request to write the head store to memory.
- st_id  out  RBITS  ROB index of the requested store.
- exc_take  out  1  one-cycle pulse when an exception entry retires.
- exc_id  out  RBITS  ROB index of the excepting entry; registered.
- flush  out  1  pipeline flush.
- commit_cnt  out  32  total retired instructions; registered.

Behaviour:
- Slot k (0..RSLOTS-1) refers to entry (rob_head + k) mod RENTRIES. Wrap-around uses RBITS-bit truncation.
- Candidate count c: the number of leading slots, starting at slot 0, that are v & done & !exc & !store. The scan stops at the first slot that fails.
- The first non-candidate slot f = slot c (if c < RSLOTS) is handled as follows:
  - f is a done store, and the state is RUN:
    - c > 0: retire c entries; the store waits for a later cycle.
    - c == 0: st_req=1, st_id=index(f), and the FSM moves to ST_WAIT.
  - f is done with exc set:
    - c > 0: retire c first.
    - c == 0: ramt=1, exc_take=1, exc_id<=index(f), enter FLUSH.
- FSM states: RUN, ST_WAIT, FLUSH.
  - RUN: ramt=c as above. In the store and exception cases, ramt follows the rules in the f cases.
  - ST_WAIT: st_req held at 1 and st_id stable; ramt=0. When st_ack=1, ramt=1 in that same cycle and the next state is RUN.
    - st_ack in the same cycle as the RUN request: ramt=1 that cycle, and the FSM stays in RUN.
  - FLUSH: flush=1, ramt=0. A down-counter loaded with FLUSH_CYCLES-1 on entry; the FSM returns to RUN when it reaches 0. flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after exc_take.
- Store with exc set: treated as an exception, and no st_req is issued.
- st_ack outside ST_WAIT, or outside a RUN cycle with st_req=1: ignored.
- Empty ROB (slot 0 invalid): ramt=0, st_req=0.
- ramt never exceeds RSLOTS and never counts past an invalid or not-done entry.
- commit_cnt <= commit_cnt + ramt every cycle; it wraps modulo 2^32.
- Reset values:
  - state=RUN, flush=0, exc_id=0, commit_cnt=0, flush counter=0.
  - Combinational outputs follow from state RUN.
- Reset asserted mid-ST_WAIT or mid-FLUSH: the FSM returns to RUN the next cycle, and a pending store request is dropped.
- rob_head is expected to advance by the previous ramt. This block does not track the head itself.

Decomposition:
- Shared package holds:
  - the Rid typedef (RBITS wide);
  - the commit FSM state enum {RUN, ST_WAIT, FLUSH};
  - the RENTRIES and RSLOTS config constants, shared with the head-pointer block.
- One natural sub-module, rob_commit_scan: purely combinational. It takes the head and status vectors and produces c, the first-stop slot type and the stop index. rob_commit holds the FSM, the counters and the outputs.

Test Plan:
- Head=14, entries 14,15 v&done, no store/exc → ramt=2 (wrap to 0); commit_cnt +2 next cycle.
- Head=3, entry 3 done, entry 4 valid not done → ramt=1.
- Head=5, entry 5 a done store:
  - st_ack low for 3 cycles → st_req=1, st_id=5, ramt=0 throughout;
  - cycle 4 st_ack=1 → ramt=1; the next cycle the FSM is in RUN.
- Head=7, entries 7 done, 8 done+exc, RSLOTS=2:
  - cycle 0: ramt=1;
  - cycle 1 (head=8): ramt=1, exc_take=1, exc_id=8;
  - then flush=1 for 3 cycles with ramt=0.
- Assert rst during the second FLUSH cycle → next cycle flush=0, state RUN, commit_cnt=0.
- ROB empty (rob_v=0) for 10 cycles → ramt=0, st_req=0, commit_cnt unchanged.
